// File: rtl/ifetch_sram_master.sv
// Instruction-fetch front end: PC sequencing, sram-like request/handshake, one-entry
// instruction buffer and redirect handling. Optional IFETCH_ADEF_EN adds misaligned-PC exceptions.
module ifetch_sram_master #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        id_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_pc,
  output logic [31:0] fs_to_ds_inst,
  output logic        fs_to_ds_adef
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] redir_pc, redir_pc_nxt;
  logic [31:0] inst_buf, inst_buf_nxt;
  logic        cancel, cancel_nxt;
  logic        rd;
  logic [31:0] rd_target;
  logic        issue_ok;

  // flush outranks a simultaneous branch
  assign rd        = flush | br_taken;
  assign rd_target = flush ? flush_target : br_target;

`ifdef IFETCH_ADEF_EN
  logic adef, adef_nxt;
  assign issue_ok      = (pc[1:0] == 2'b00);
  assign fs_to_ds_adef = adef;
`else
  assign issue_ok      = 1'b1;
  assign fs_to_ds_adef = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      redir_pc <= 32'h0;
      inst_buf <= 32'h0;
      cancel   <= 1'b0;
`ifdef IFETCH_ADEF_EN
      adef     <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      redir_pc <= redir_pc_nxt;
      inst_buf <= inst_buf_nxt;
      cancel   <= cancel_nxt;
`ifdef IFETCH_ADEF_EN
      adef     <= adef_nxt;
`endif
    end
  end

  // Next-state logic; a pending request is never altered, only its data cancelled
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    redir_pc_nxt = redir_pc;
    inst_buf_nxt = inst_buf;
    cancel_nxt   = cancel;
`ifdef IFETCH_ADEF_EN
    adef_nxt     = adef;
`endif
    case (state)
      S_REQ: begin
`ifdef IFETCH_ADEF_EN
        if (!issue_ok) begin
          // nothing is on the bus, so a redirect can retarget pc directly
          if (rd) begin
            pc_nxt = rd_target;
          end else begin
            state_nxt    = S_HOLD;
            inst_buf_nxt = 32'h0;
            adef_nxt     = 1'b1;
          end
        end else
`endif
        begin
          if (rd) begin
            cancel_nxt   = 1'b1;
            redir_pc_nxt = rd_target;
          end
          if (inst_sram_addr_ok) state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          if (cancel || rd) begin
            pc_nxt     = rd ? rd_target : redir_pc;
            cancel_nxt = 1'b0;
            state_nxt  = S_REQ;
          end else begin
            inst_buf_nxt = inst_sram_rdata;
            state_nxt    = S_HOLD;
          end
        end else if (rd) begin
          cancel_nxt   = 1'b1;
          redir_pc_nxt = rd_target;
        end
      end
      S_HOLD: begin
        if (rd) begin
          pc_nxt    = rd_target;
          state_nxt = S_REQ;
`ifdef IFETCH_ADEF_EN
          adef_nxt  = 1'b0;
`endif
        end else if (id_allowin) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = S_REQ;
`ifdef IFETCH_ADEF_EN
          adef_nxt  = 1'b0;
`endif
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // Handshake and decode-side outputs are pure decodes of registered state
  assign inst_sram_req   = resetn & (state == S_REQ) & issue_ok;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_addr  = pc;
  assign inst_sram_wdata = 32'h0;

  assign fs_to_ds_valid  = resetn & (state == S_HOLD);
  assign fs_to_ds_pc     = pc;
  assign fs_to_ds_inst   = inst_buf;

endmodule

// File: tb/tb_ifetch_sram_master.sv
// Self-checking bench for ifetch_sram_master: directed vector table, hand-written
// redirect/reset sequences, and a randomized slave checked against a transaction-level model.
module tb_ifetch_sram_master;

  localparam logic [31:0] B = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        id_allowin, br_taken, flush;
  logic [31:0] br_target, flush_target;
  logic        fs_to_ds_valid, fs_to_ds_adef;
  logic [31:0] fs_to_ds_pc, fs_to_ds_inst;

  int n_tests = 0;
  int n_fail  = 0;

  ifetch_sram_master #(.RESET_PC(B)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .id_allowin(id_allowin), .br_taken(br_taken), .br_target(br_target),
    .flush(flush), .flush_target(flush_target),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_pc(fs_to_ds_pc),
    .fs_to_ds_inst(fs_to_ds_inst), .fs_to_ds_adef(fs_to_ds_adef)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        aok, dok;
    logic [31:0] rdata;
    logic        allow, br;
    logic [31:0] bt;
    logic        fl;
    logic [31:0] ft;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc, einst;
  } vec_t;

  localparam int NV = 28;
  vec_t tv [NV];

  function automatic vec_t mk(logic aok, logic dok, logic [31:0] rdata, logic allow,
                              logic br, logic [31:0] bt, logic fl, logic [31:0] ft,
                              logic ereq, logic [31:0] eaddr, logic evalid,
                              logic [31:0] epc, logic [31:0] einst);
    vec_t v;
    v.aok = aok; v.dok = dok; v.rdata = rdata; v.allow = allow;
    v.br = br; v.bt = bt; v.fl = fl; v.ft = ft;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epc = epc; v.einst = einst;
    return v;
  endfunction

  // Memory image returned by the random slave: a bijection of the address
  function automatic logic [31:0] mem(logic [31:0] a);
    return (a ^ 32'h3c3c_a5a5) + 32'h0101_0101;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_in();
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
    id_allowin = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    flush = 1'b0; flush_target = 32'h0;
  endtask

  task automatic do_reset();
    clr_in();
    resetn = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
    #1;
  endtask

  // Random-phase model: which fetch is in progress, expressed as transaction flags
  logic [31:0] m_pc, m_next;
  logic        m_out, m_full, m_kill;
  logic        s_busy;
  logic [31:0] s_addr;
  int          s_delay;

  initial begin
    // Directed table: three sequential fetches, decode stall, redirect under addr_ok=0,
    // flush+branch on data_ok, hold-state redirect to top of memory and wrap to 0.
    tv[0]  = mk(1,0,0,0, 0,0,0,0, 1,B,0,0,0);
    tv[1]  = mk(0,1,32'h1111_0000,0, 0,0,0,0, 0,0,0,0,0);
    tv[2]  = mk(0,0,0,1, 0,0,0,0, 0,0,1,B,32'h1111_0000);
    tv[3]  = mk(1,0,0,0, 0,0,0,0, 1,B+4,0,0,0);
    tv[4]  = mk(0,1,32'h2222_0004,0, 0,0,0,0, 0,0,0,0,0);
    tv[5]  = mk(0,0,0,1, 0,0,0,0, 0,0,1,B+4,32'h2222_0004);
    tv[6]  = mk(1,0,0,0, 0,0,0,0, 1,B+8,0,0,0);
    tv[7]  = mk(0,1,32'h3333_0008,0, 0,0,0,0, 0,0,0,0,0);
    tv[8]  = mk(0,0,0,0, 0,0,0,0, 0,0,1,B+8,32'h3333_0008);
    tv[9]  = mk(0,0,0,0, 0,0,0,0, 0,0,1,B+8,32'h3333_0008);
    tv[10] = mk(0,0,0,0, 0,0,0,0, 0,0,1,B+8,32'h3333_0008);
    tv[11] = mk(0,0,0,1, 0,0,0,0, 0,0,1,B+8,32'h3333_0008);
    tv[12] = mk(0,0,0,0, 1,B+32'h100,0,0, 1,B+12,0,0,0);
    tv[13] = mk(0,0,0,0, 0,0,0,0, 1,B+12,0,0,0);
    tv[14] = mk(0,0,0,0, 0,0,0,0, 1,B+12,0,0,0);
    tv[15] = mk(0,0,0,0, 0,0,0,0, 1,B+12,0,0,0);
    tv[16] = mk(0,0,0,0, 0,0,0,0, 1,B+12,0,0,0);
    tv[17] = mk(1,0,0,0, 0,0,0,0, 1,B+12,0,0,0);
    tv[18] = mk(0,1,32'hdead_dead,0, 0,0,0,0, 0,0,0,0,0);
    tv[19] = mk(1,0,0,0, 0,0,0,0, 1,B+32'h100,0,0,0);
    tv[20] = mk(0,1,32'h4444_0100,0, 1,B+32'h200,1,B+32'h8000, 0,0,0,0,0);
    tv[21] = mk(1,0,0,0, 0,0,0,0, 1,B+32'h8000,0,0,0);
    tv[22] = mk(0,1,32'h5555_8000,0, 0,0,0,0, 0,0,0,0,0);
    tv[23] = mk(0,0,0,1, 1,32'hffff_fffc,0,0, 0,0,1,B+32'h8000,32'h5555_8000);
    tv[24] = mk(1,0,0,0, 0,0,0,0, 1,32'hffff_fffc,0,0,0);
    tv[25] = mk(0,1,32'h6666_fffc,0, 0,0,0,0, 0,0,0,0,0);
    tv[26] = mk(0,0,0,1, 0,0,0,0, 0,0,1,32'hffff_fffc,32'h6666_fffc);
    tv[27] = mk(0,0,0,0, 0,0,0,0, 1,32'h0,0,0,0);

    clr_in();
    resetn = 1'b0;
    step();
    step();
    chk("rst_req",   32'(inst_sram_req),  32'd0);
    chk("rst_valid", 32'(fs_to_ds_valid), 32'd0);
    chk("rst_adef",  32'(fs_to_ds_adef),  32'd0);
    chk("const_wr",    32'(inst_sram_wr),    32'd0);
    chk("const_size",  32'(inst_sram_size),  32'd2);
    chk("const_wstrb", 32'(inst_sram_wstrb), 32'd0);
    chk("const_wdata", inst_sram_wdata,      32'd0);
    resetn = 1'b1;
    #1;

    for (int i = 0; i < NV; i++) begin
      chk($sformatf("v%0d_req", i), 32'(inst_sram_req), 32'(tv[i].ereq));
      if (tv[i].ereq) chk($sformatf("v%0d_addr", i), inst_sram_addr, tv[i].eaddr);
      chk($sformatf("v%0d_valid", i), 32'(fs_to_ds_valid), 32'(tv[i].evalid));
      if (tv[i].evalid) begin
        chk($sformatf("v%0d_pc", i),   fs_to_ds_pc,   tv[i].epc);
        chk($sformatf("v%0d_inst", i), fs_to_ds_inst, tv[i].einst);
      end
      inst_sram_addr_ok = tv[i].aok; inst_sram_data_ok = tv[i].dok;
      inst_sram_rdata = tv[i].rdata; id_allowin = tv[i].allow;
      br_taken = tv[i].br; br_target = tv[i].bt;
      flush = tv[i].fl; flush_target = tv[i].ft;
      step();
    end

    // Redirects while awaiting data: the latest target wins once data returns
    do_reset();
    inst_sram_addr_ok = 1'b1; step(); clr_in();
    br_taken = 1'b1; br_target = B + 32'h300; step(); clr_in();
    chk("wait_rd_noreq", 32'(inst_sram_req), 32'd0);
    flush = 1'b1; flush_target = B + 32'h400; step(); clr_in();
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hbad0_bad0; step(); clr_in();
    chk("wait_rd_valid", 32'(fs_to_ds_valid), 32'd0);
    chk("wait_rd_req",   32'(inst_sram_req),  32'd1);
    chk("wait_rd_addr",  inst_sram_addr,      B + 32'h400);

    // Reset while a response is outstanding: the late data_ok must be ignored
    inst_sram_addr_ok = 1'b1; step(); clr_in();
    resetn = 1'b0; step();
    chk("midrst_req", 32'(inst_sram_req), 32'd0);
    resetn = 1'b1; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hbad1_bad1; step(); clr_in();
    chk("midrst_valid", 32'(fs_to_ds_valid), 32'd0);
    chk("midrst_req2",  32'(inst_sram_req),  32'd1);
    chk("midrst_addr",  inst_sram_addr,      B);
    inst_sram_addr_ok = 1'b1; step(); clr_in();
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h7777_0000; step(); clr_in();
    chk("midrst_dvalid", 32'(fs_to_ds_valid), 32'd1);
    chk("midrst_dpc",    fs_to_ds_pc,         B);
    chk("midrst_dinst",  fs_to_ds_inst,       32'h7777_0000);

`ifdef IFETCH_ADEF_EN
    // Misaligned branch target raises a fetch-address exception without a request
    do_reset();
    inst_sram_addr_ok = 1'b1; step(); clr_in();
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h1234_5678; step(); clr_in();
    br_taken = 1'b1; br_target = B + 32'h102; step(); clr_in();
    chk("adef_noreq", 32'(inst_sram_req), 32'd0);
    step();
    chk("adef_valid", 32'(fs_to_ds_valid), 32'd1);
    chk("adef_flag",  32'(fs_to_ds_adef),  32'd1);
    chk("adef_pc",    fs_to_ds_pc,         B + 32'h102);
    chk("adef_inst",  fs_to_ds_inst,       32'h0);
    id_allowin = 1'b1; step(); clr_in();
    chk("adef_clear", 32'(fs_to_ds_adef),  32'd0);
`endif

    // Randomized traffic against the transaction-level model
    do_reset();
    m_pc = B; m_next = 32'h0; m_out = 1'b0; m_full = 1'b0; m_kill = 1'b0;
    s_busy = 1'b0; s_addr = 32'h0; s_delay = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic aok, dok, allow, br, fl, rdv, acc;
      logic [31:0] bt, ft, rdata, tgt;
      // A fetch is requested whenever nothing is in flight and nothing is buffered
      chk("rnd_req", 32'(inst_sram_req), 32'(!m_out && !m_full));
      if (!m_out && !m_full) chk("rnd_addr", inst_sram_addr, m_pc);
      chk("rnd_valid", 32'(fs_to_ds_valid), 32'(m_full));
      if (m_full) begin
        chk("rnd_pc",   fs_to_ds_pc,   m_pc);
        chk("rnd_inst", fs_to_ds_inst, mem(m_pc));
      end

      aok   = ($urandom_range(0, 1) == 1);
      allow = ($urandom_range(0, 1) == 1);
      br    = ($urandom_range(0, 9) == 0);
      fl    = ($urandom_range(0, 11) == 0);
      bt    = $urandom & 32'hffff_fffc;
      ft    = $urandom & 32'hffff_fffc;
      dok   = 1'b0;
      rdata = $urandom;
      if (s_busy) begin
        if (s_delay == 0) begin
          dok = ($urandom_range(0, 9) < 6);
          if (dok) rdata = mem(s_addr);
        end else begin
          s_delay--;
        end
      end else begin
        dok = ($urandom_range(0, 19) == 0);
      end
      acc = inst_sram_req && aok;

      inst_sram_addr_ok = aok; inst_sram_data_ok = dok; inst_sram_rdata = rdata;
      id_allowin = allow; br_taken = br; br_target = bt; flush = fl; flush_target = ft;

      if (s_busy && dok) s_busy = 1'b0;
      if (acc) begin
        s_busy = 1'b1; s_addr = inst_sram_addr; s_delay = int'($urandom_range(0, 2));
      end

      rdv = fl | br;
      tgt = fl ? ft : bt;
      if (m_full) begin
        if (rdv)        begin m_full = 1'b0; m_pc = tgt; end
        else if (allow) begin m_full = 1'b0; m_pc = m_pc + 32'd4; end
      end else if (m_out) begin
        if (dok) begin
          m_out = 1'b0;
          if (m_kill || rdv) begin m_pc = rdv ? tgt : m_next; m_kill = 1'b0; end
          else m_full = 1'b1;
        end else if (rdv) begin
          m_kill = 1'b1; m_next = tgt;
        end
      end else begin
        if (rdv) begin m_kill = 1'b1; m_next = tgt; end
        if (aok) m_out = 1'b1;
      end

      step();
    end
    chk("rnd_adef", 32'(fs_to_ds_adef), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_sram_master.md
# ifetch_sram_master

Instruction-fetch front end sitting directly upstream of `sram_axi_bridge` on its instruction port. It generates the PC sequence, drives the sram-like request/handshake (`inst_sram_*`), buffers one returned instruction for the decode stage, and handles branch/flush redirects. Redirects never disturb a request already on the bus; they cancel its data instead. At most one request is outstanding at any time.

## Interface
Parameters:
- `RESET_PC`, default 32'h1c00_0000, first fetch address after reset.

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  reset, synchronous, active-low
- `inst_sram_req`  out  1  request valid
- `inst_sram_wr`  out  1  constant 0
- `inst_sram_size`  out  2  constant 2'b10
- `inst_sram_wstrb`  out  4  constant 4'b0
- `inst_sram_addr`  out  32  fetch address, equal to `pc`
- `inst_sram_wdata`  out  32  constant 0
- `inst_sram_addr_ok`  in  1  request accepted
- `inst_sram_data_ok`  in  1  read data valid
- `inst_sram_rdata`  in  32  instruction word
- `id_allowin`  in  1  decode can accept an instruction
- `br_taken`  in  1  decode redirect, one-cycle pulse
- `br_target`  in  32  branch target
- `flush`  in  1  writeback redirect (exception/ertn), one-cycle pulse
- `flush_target`  in  32  flush target
- `fs_to_ds_valid`  out  1  buffered instruction valid
- `fs_to_ds_pc`  out  32  PC of buffered instruction
- `fs_to_ds_inst`  out  32  buffered instruction
- `fs_to_ds_adef`  out  1  fetch-address exception flag

## Operation
- Registers: `pc`, `redir_pc`, `cancel`, `inst_buf`, state.
- States:
  - S_REQ: `inst_sram_req`=1.
  - S_WAIT: address accepted, awaiting `data_ok`.
  - S_HOLD: instruction buffered, `fs_to_ds_valid`=1.
- Redirect event `rd` = `flush | br_taken`. Its target is `flush_target` if `flush`, else `br_target`; `flush` wins.
- S_REQ:
  - `addr_ok` → S_WAIT.
  - `inst_sram_addr` stays stable while `req`=1 and `addr_ok`=0. A redirect never changes the address of a pending request.
- S_REQ with `rd`, with or without `addr_ok` in the same cycle: `cancel`←1, `redir_pc`←target. The request still completes.
- S_WAIT with `data_ok`:
  - `cancel`=0 and no `rd`: `inst_buf`←`rdata`, go to S_HOLD.
  - `cancel`=1 or `rd`: discard data, `pc`←(`rd` ? target : `redir_pc`), `cancel`←0, go to S_REQ.
- S_WAIT with `rd` and no `data_ok`: `cancel`←1, `redir_pc`←target. Stay in S_WAIT.
- S_HOLD:
  - `rd`: drop buffer, `pc`←target, go to S_REQ. This takes priority over `id_allowin`.
  - else `id_allowin`: `pc`←`pc`+4 (32-bit wrap), go to S_REQ.
  - else hold.
- Repeated redirects while `cancel`=1: `redir_pc` takes the latest target. `cancel` stays 1, since only one request is outstanding.
- `fs_to_ds_valid` = (state==S_HOLD). `fs_to_ds_pc` = `pc`. `fs_to_ds_inst` = `inst_buf`.
- A `data_ok` seen in S_REQ or S_HOLD is a protocol error. It is ignored.

## Timing
- Reset values:
  - state S_REQ, `pc`=`RESET_PC`, `cancel`=0, `inst_buf`=0, `redir_pc`=0.
  - Outputs: `inst_sram_req`=0 during the reset cycle, `fs_to_ds_valid`=0, `fs_to_ds_adef`=0.
- `req` rises in the first cycle with `resetn`=1.
- Best-case latency:
  - `addr_ok` in cycle N.
  - `data_ok` in cycle N+1.
  - `fs_to_ds_valid` in cycle N+2.
  - Next `req` in the cycle after the handshake with `id_allowin`.
- Issue rate: one fetch per three cycles minimum. There are no back-to-back requests.
- `resetn` low mid-operation returns to reset values on the next edge. Any in-flight response arriving after reset is ignored, because state is S_REQ.

## Configuration
- `IFETCH_ADEF_EN` defined, in S_REQ with `pc[1:0]`≠0:
  - `req` is not asserted.
  - Next cycle goes to S_HOLD with `inst_buf`=0 and `fs_to_ds_adef`=1.
  - `fs_to_ds_adef` clears when leaving S_HOLD.
- `IFETCH_ADEF_EN` undefined:
  - `fs_to_ds_adef` is tied to 0.
  - Misaligned `pc` is issued unchanged on `inst_sram_addr`.

## Test plan
- Reset release, slave with `addr_ok`=1 and `data_ok` one cycle later, `id_allowin`=1 → requests at 1c000000, 1c000004, 1c000008, each delivered with the correct `fs_to_ds_pc`/`fs_to_ds_inst`.
- Hold `addr_ok`=0 for 5 cycles while pulsing `br_taken` with target 1c000100 → `inst_sram_addr` stays 1c000000 until accepted; returned data is discarded; next request is to 1c000100.
- In S_WAIT, `flush` (target 1c008000) and `br_taken` (target 1c000200) in the same cycle as `data_ok` → data discarded, next address 1c008000.
- S_HOLD with `id_allowin`=0 for 4 cycles → `fs_to_ds_*` stable, no `req`; then `id_allowin`=1 → next request to `pc`+4.
- `pc` 32'hFFFF_FFFC delivered and accepted → next address 0.
- With `IFETCH_ADEF_EN`, branch to 1c000102 → no `req`; `fs_to_ds_valid`=1 with `adef`=1 and `pc` 1c000102.
